button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter.sv | 104 ++++++++++
 tb/tb_button_event_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// Collects one-cycle button presses into per-button pending bits, grants them
// round-robin into a small first-word-fall-through event queue.
module button_event_arbiter #(
   parameter int NUM_BTN    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_BTN-1:0]            btn_pulse,
   input  logic                          evt_ready,
   input  logic                          ovf_clr,
   output logic                          evt_valid,
   output logic [1:0]                    evt_code,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          ovf
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [NUM_BTN-1:0] pend;
   logic [NUM_BTN-1:0] pend_nxt;
   logic [NUM_BTN-1:0] grant_vec;
   logic [1:0]         last_grant;
   logic [1:0]         grant_idx;
   logic [1:0]         cand_idx;
   logic               grant_vld;
   logic [1:0]         mem [FIFO_DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic               push;
   logic               pop;
   logic               ovf_set;

   // Grant sees only the occupancy at cycle start; a same-cycle pop does not help.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = last_grant;
      cand_idx  = '0;
      if (count < CW'(FIFO_DEPTH)) begin
         for (int k = 1; k <= NUM_BTN; k++) begin
            cand_idx = last_grant + 2'(k);
            if (!grant_vld && pend[cand_idx]) begin
               grant_vld = 1'b1;
               grant_idx = cand_idx;
            end
         end
      end
   end

   always_comb begin
      grant_vec = '0;
      if (grant_vld)
         grant_vec = NUM_BTN'(1) << grant_idx;
      // A press arriving on the cycle its pending bit is granted re-arms the bit.
      pend_nxt  = (pend & ~grant_vec) | btn_pulse;
      ovf_set   = |(pend & btn_pulse & ~grant_vec);
      push      = grant_vld;
      pop       = evt_valid && evt_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= '0;
         last_grant <= 2'(NUM_BTN - 1);
         ovf        <= 1'b0;
      end else begin
         pend <= pend_nxt;
         if (grant_vld)
            last_grant <= grant_idx;
         if (ovf_set)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= grant_idx;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   assign evt_valid = (count != '0);
   assign evt_code  = mem[rd_ptr];
   assign evt_count = count;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: drives on the falling edge, checks
// outputs on the falling edge after each rising edge.
module tb_button_event_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn_pulse;
   logic       evt_ready;
   logic       ovf_clr;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic [2:0] evt_count;
   logic       ovf;

   int total = 0;
   int bad   = 0;

   button_event_arbiter #(.NUM_BTN(4), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_pulse (btn_pulse),
      .evt_ready (evt_ready),
      .ovf_clr   (ovf_clr),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .evt_count (evt_count),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      btn_pulse = 4'hF;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      tick();
      tick();
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_code",  32'(evt_code),  32'd0);
      chk("rst_count", 32'(evt_count), 32'd0);
      chk("rst_ovf",   32'(ovf),       32'd0);
      btn_pulse = 4'h0;
      rst_n     = 1'b1;
      tick();
      tick();
      chk("rst_pulse_ignored", 32'(evt_count), 32'd0);

      // single press on button 2 with consumer always ready
      btn_pulse = 4'b0100;
      evt_ready = 1'b1;
      tick();
      btn_pulse = 4'b0000;
      chk("t1_valid_e0", 32'(evt_valid), 32'd0);
      tick();
      chk("t1_valid_e1", 32'(evt_valid), 32'd1);
      chk("t1_code_e1",  32'(evt_code),  32'd2);
      chk("t1_count_e1", 32'(evt_count), 32'd1);
      tick();
      chk("t1_count_e2", 32'(evt_count), 32'd0);
      chk("t1_valid_e2", 32'(evt_valid), 32'd0);

      // simultaneous presses 0,1,3 after a fresh reset
      evt_ready = 1'b0;
      rst_n     = 1'b0;
      tick();
      rst_n     = 1'b1;
      tick();
      btn_pulse = 4'b1011;
      tick();
      btn_pulse = 4'b0000;
      tick();
      tick();
      tick();
      chk("t2_count", 32'(evt_count), 32'd3);
      chk("t2_code0", 32'(evt_code),  32'd0);
      chk("t2_ovf",   32'(ovf),       32'd0);
      evt_ready = 1'b1;
      tick();
      chk("t2_code1", 32'(evt_code),  32'd1);
      tick();
      chk("t2_code3", 32'(evt_code),  32'd3);
      tick();
      chk("t2_empty", 32'(evt_count), 32'd0);
      evt_ready = 1'b0;

      // fill the queue, then hold and overflow pending presses
      btn_pulse = 4'b1111;
      tick();
      btn_pulse = 4'b0000;
      tick();
      tick();
      tick();
      tick();
      chk("t3_full",      32'(evt_count), 32'd4);
      chk("t3_head",      32'(evt_code),  32'd0);
      btn_pulse = 4'b0010;
      tick();
      chk("t3_held_full", 32'(evt_count), 32'd4);
      btn_pulse = 4'b1000;
      tick();
      chk("t3_pend3_noovf", 32'(ovf), 32'd0);
      tick();
      chk("t3_ovf_set", 32'(ovf), 32'd1);
      ovf_clr   = 1'b1;
      tick();
      chk("t3_ovf_set_wins", 32'(ovf), 32'd1);
      btn_pulse = 4'b0000;
      tick();
      chk("t3_ovf_clr", 32'(ovf), 32'd0);
      ovf_clr   = 1'b0;
      evt_ready = 1'b1;
      tick();
      chk("t3_pop_count", 32'(evt_count), 32'd3);
      chk("t3_pop_code",  32'(evt_code),  32'd1);
      evt_ready = 1'b0;
      tick();
      chk("t3_refill", 32'(evt_count), 32'd4);
      evt_ready = 1'b1;
      tick();
      chk("t3_c_code",  32'(evt_code),  32'd2);
      chk("t3_c_count", 32'(evt_count), 32'd3);
      tick();
      chk("t3_d_code",  32'(evt_code),  32'd3);
      chk("t3_d_count", 32'(evt_count), 32'd3);
      tick();
      chk("t3_e_code",  32'(evt_code),  32'd1);
      tick();
      chk("t3_f_code",  32'(evt_code),  32'd3);
      tick();
      chk("t3_drained", 32'(evt_valid), 32'd0);

      // all buttons every 4 cycles with continuous consumer
      for (int k = 0; k <= 12; k++) begin
         btn_pulse = ((k % 4 == 0) && (k <= 8)) ? 4'b1111 : 4'b0000;
         tick();
         if (k >= 1) begin
            chk("t4_valid", 32'(evt_valid), 32'd1);
            chk("t4_code",  32'(evt_code),  32'((k - 1) % 4));
         end
         chk("t4_ovf",   32'(ovf), 32'd0);
         chk("t4_count_le2", 32'(evt_count <= 3'd2), 32'd1);
      end
      btn_pulse = 4'b0000;
      tick();
      chk("t4_drained", 32'(evt_count), 32'd0);

      // reset mid-operation with queued and pending events
      evt_ready = 1'b0;
      btn_pulse = 4'b0111;
      tick();
      btn_pulse = 4'b0000;
      tick();
      tick();
      tick();
      btn_pulse = 4'b1001;
      tick();
      btn_pulse = 4'b0000;
      chk("t5_pre_count", 32'(evt_count), 32'd3);
      rst_n     = 1'b0;
      #1;
      chk("t5_async_valid", 32'(evt_valid), 32'd0);
      chk("t5_async_count", 32'(evt_count), 32'd0);
      chk("t5_async_ovf",   32'(ovf),       32'd0);
      btn_pulse = 4'b1111;
      tick();
      tick();
      btn_pulse = 4'b0000;
      rst_n     = 1'b1;
      tick();
      tick();
      chk("t5_post_empty", 32'(evt_count), 32'd0);
      btn_pulse = 4'b0001;
      tick();
      btn_pulse = 4'b0000;
      chk("t5_e0_valid", 32'(evt_valid), 32'd0);
      tick();
      chk("t5_e1_valid", 32'(evt_valid), 32'd1);
      chk("t5_e1_code",  32'(evt_code),  32'd0);
      chk("t5_e1_count", 32'(evt_count), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
